key_bounce_gen: RTL
===================

Name: key_bounce_gen

Overview:
Synthesizable generator of a realistic mechanical-key waveform, the driving end of the key input that our debouncer samples.
- Each press request produces one key stroke on key_o: idle high, press bounce, stable low hold, release bounce, stable high settle.
- Bounce segments are LFSR-randomised and always shorter than the glitch window.
- Used in demo top-levels and benches to exercise the debouncer chain in hardware.

Parameters:
CLK_FREQ_MHZ, 20, clock frequency; GLITCH_CYCLES = GLITCH_TIME_NS*CLK_FREQ_MHZ/1000.
GLITCH_TIME_NS, 1000, glitch window of the downstream debouncer; GLITCH_CYCLES must be >= 2.
BOUNCE_EDGES, 4, bounce pulse pairs per bounce phase (0 = clean edges).
HOLD_CYCLES, 64, cycles key_o stays stable low after press bounce; must be >= 1.
LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous active-low reset
press_stb_i  in  1  one-cycle request for one key stroke
key_o  out  1  emulated key line, idle high, pressed low
busy_o  out  1  stroke in progress
done_stb_o  out  1  one-cycle pulse at end of stroke
drop_stb_o  out  1  one-cycle pulse when press_stb_i is ignored

Behaviour:
- Reset (arstn_i low, asynchronous):
  - key_o=1, busy_o=0, done_stb_o=0, drop_stb_o=0.
  - State IDLE, all counters 0, LFSR=seed.
  - Reset mid-stroke aborts the stroke immediately; key_o returns high without bounce.
- LFSR: 16-bit Galois, taps 16'hB400, advances every cycle in every state.
- Segment length L = 1 + (lfsr[7:0] mod (GLITCH_CYCLES-1)), range [1, GLITCH_CYCLES-1]. L is sampled at each segment start.
- Toggle target per bounce phase T = 2*BOUNCE_EDGES+1 (odd, so each phase ends on the opposite level).
- SETTLE_CYCLES = 2*GLITCH_CYCLES.
- IDLE:
  - key_o=1, busy_o=0.
  - press_stb_i=1 in cycle t -> from t+1: state PBOUNCE, key_o=0 (toggle 1), busy_o=1.
- PBOUNCE:
  - Each toggle other than the T-th starts a segment of L cycles.
  - At segment end, key_o toggles and the toggle count increments.
  - The cycle carrying the T-th toggle (key_o=0) is HOLD cycle 1. With BOUNCE_EDGES=0, HOLD starts at t+1.
- HOLD: key_o=0 for exactly HOLD_CYCLES cycles, then RBOUNCE with key_o=1 (toggle 1).
- RBOUNCE: mirror of PBOUNCE. The T-th toggle leaves key_o=1 and is SETTLE cycle 1.
- SETTLE: key_o=1 for exactly SETTLE_CYCLES cycles, then DONE.
- DONE:
  - One cycle with done_stb_o=1, busy_o=1, key_o=1.
  - Next cycle IDLE.
  - A press_stb_i in the DONE cycle is dropped.
- busy_o=1 in every non-IDLE state.
- press_stb_i while busy_o=1: request discarded, drop_stb_o=1 in the following cycle. No queueing.
- Outputs are registered; key_o is glitch-free (driven directly from a flop).
- Counter widths: $clog2(max(GLITCH_CYCLES, HOLD_CYCLES, SETTLE_CYCLES))+1 bits; counters never wrap.
- Implementation size: roughly 150-250 lines.

Decomposition:
- Package key_pkg:
  - typedef enum logic [2:0] key_gen_state_t {IDLE, PBOUNCE, HOLD, RBOUNCE, SETTLE, DONE}.
  - LFSR_TAPS = 16'hB400.
  - Function glitch_cycles(freq_mhz, glitch_ns), shared with the debouncer's width calculation.
- One sub-module: lfsr16 (clk_i, arstn_i, seed parameter, 16-bit state output).
- FSM and counters live in key_bounce_gen.

Test Plan:
- Defaults, BOUNCE_EDGES=0, press_stb_i at cycle 10 -> key_o low cycles 11..74, high from 75; done_stb_o at cycle 115; busy_o 11..115; exactly 2 key_o edges.
- Defaults, BOUNCE_EDGES=4, one press ->
  - 9 key_o edges per bounce phase, every intermediate pulse width in [1,19].
  - Final low run >= 64; done_stb_o once.
  - Waveform deterministic for seed ACE1 (golden compare).
- key_bounce_gen driving debouncer (same CLK_FREQ_MHZ/GLITCH_TIME_NS), 20 back-to-back strokes -> exactly 20 key_pressed_stb_o pulses.
- press_stb_i at t and t+5 -> second request ignored, drop_stb_o=1 at t+6, stroke timing unchanged.
- press_stb_i asserted in the DONE cycle -> drop_stb_o next cycle, IDLE with key_o=1.
- arstn_i low during HOLD (key_o=0) -> key_o=1 and busy_o=0 without waiting for a clock edge; next press_stb_i reproduces the post-reset golden waveform.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared types, constants and helpers for the key-stroke generator.
//   key_gen_state_t : stroke FSM states
//   LFSR_TAPS       : Galois feedback mask for the 16-bit randomiser
//   glitch_cycles() : glitch window in clock cycles (also used by the debouncer)
//   lfsr_next()     : one Galois LFSR step
package key_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PBOUNCE = 3'd1,
        HOLD    = 3'd2,
        RBOUNCE = 3'd3,
        SETTLE  = 3'd4,
        DONE    = 3'd5
    } key_gen_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int glitch_cycles(input int freq_mhz, input int glitch_ns);
        return (glitch_ns * freq_mhz) / 1000;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/key_bounce_gen_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, advances every clock.
//   clk_i   : clock
//   arstn_i : asynchronous active-low reset (loads SEED)
//   state_o : current LFSR state
module lfsr16 import key_pkg::*; #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    output logic [15:0] state_o
);

    // An all-zero state would lock the LFSR, so a zero seed is remapped.
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] state_q, state_d;

    always_comb state_d = lfsr_next(state_q);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) state_q <= SEED_NZ;
        else          state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/key_bounce_gen.sv
// key_bounce_gen: emulates one mechanical key stroke per press request:
// idle high, press bounce, stable low hold, release bounce, stable high settle.
//   clk_i       : clock
//   arstn_i     : asynchronous active-low reset (aborts a stroke, key_o high)
//   press_stb_i : one-cycle stroke request
//   key_o       : emulated key line (idle high, pressed low), straight from a flop
//   busy_o      : stroke in progress
//   done_stb_o  : one-cycle pulse in the final cycle of a stroke
//   drop_stb_o  : one-cycle pulse after a request that arrived while busy
module key_bounce_gen import key_pkg::*; #(
    parameter int          CLK_FREQ_MHZ   = 20,
    parameter int          GLITCH_TIME_NS = 1000,
    parameter int          BOUNCE_EDGES   = 4,
    parameter int          HOLD_CYCLES    = 64,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic press_stb_i,
    output logic key_o,
    output logic busy_o,
    output logic done_stb_o,
    output logic drop_stb_o
);

    localparam int GC            = glitch_cycles(CLK_FREQ_MHZ, GLITCH_TIME_NS);
    localparam int SETTLE_CYCLES = 2 * GC;
    localparam int T             = 2 * BOUNCE_EDGES + 1;
    localparam int CW            = $clog2(max3(GC, HOLD_CYCLES, SETTLE_CYCLES)) + 1;
    localparam int TW            = $clog2(T + 1) + 1;
    // With no bounce edges the first toggle of a phase is also its last.
    localparam bit CLEAN         = (BOUNCE_EDGES == 0);

    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [TW-1:0] TOG_ONE   = TW'(1);
    localparam logic [TW-1:0] TOG_PRE   = TW'(T - 1);

    key_gen_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  tog_q, tog_d;
    logic           key_q, key_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           drop_q, drop_d;

    logic [15:0]    lfsr;
    logic [CW-1:0]  seg_len;
    logic           seg_end;
    logic           last_tog;
    logic           lfsr_unused;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .state_o (lfsr)
    );

    // Segment length in [1, GC-1] keeps every bounce pulse inside the glitch window.
    assign seg_len     = CW'(32'(lfsr[7:0]) % 32'(GC - 1)) + CNT_ONE;
    // Upper LFSR bits only feed the shift chain.
    assign lfsr_unused = ^lfsr[15:8];

    // cnt_q holds the cycles left in the current segment, including this one.
    assign seg_end  = (cnt_q == CNT_ONE);
    // Next toggle is the phase-ending one.
    assign last_tog = (tog_q == TOG_PRE);

    // State register
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (press_stb_i)          state_d = CLEAN ? HOLD : PBOUNCE;
            PBOUNCE: if (seg_end && last_tog)  state_d = HOLD;
            HOLD:    if (seg_end)              state_d = CLEAN ? SETTLE : RBOUNCE;
            RBOUNCE: if (seg_end && last_tog)  state_d = SETTLE;
            SETTLE:  if (seg_end)              state_d = DONE;
            DONE:                              state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // Output / datapath next values (all registered below)
    always_comb begin
        key_d  = key_q;
        tog_d  = tog_q;
        cnt_d  = (cnt_q != '0) ? cnt_q - CNT_ONE : '0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        drop_d = press_stb_i && busy_q;
        case (state_q)
            IDLE: begin
                if (press_stb_i) begin
                    key_d = 1'b0;
                    tog_d = TOG_ONE;
                    cnt_d = CLEAN ? HOLD_LD : seg_len;
                end
            end
            PBOUNCE, RBOUNCE: begin
                if (seg_end) begin
                    key_d = ~key_q;
                    tog_d = tog_q + TOG_ONE;
                    if (last_tog) cnt_d = (state_q == PBOUNCE) ? HOLD_LD : SETTLE_LD;
                    else          cnt_d = seg_len;
                end
            end
            HOLD: begin
                if (seg_end) begin
                    key_d = 1'b1;
                    tog_d = TOG_ONE;
                    cnt_d = CLEAN ? SETTLE_LD : seg_len;
                end
            end
            DONE: begin
                key_d = 1'b1;
                tog_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            cnt_q  <= '0;
            tog_q  <= '0;
            key_q  <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tog_q  <= tog_d;
            key_q  <= key_d;
            busy_q <= busy_d;
            done_q <= done_d;
            drop_q <= drop_d;
        end
    end

    assign key_o      = key_q;
    assign busy_o     = busy_q;
    assign done_stb_o = done_q;
    assign drop_stb_o = drop_q;

endmodule
